// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, received byte and status strobes out.
interface uart_rx_if;
    logic       sin;
    logic [7:0] dout;
    logic       rx_valid;
    logic       frame_err;
    logic       busy_rx;

    modport master (
        output sin,
        input  dout,
        input  rx_valid,
        input  frame_err,
        input  busy_rx
    );

    modport slave (
        input  sin,
        output dout,
        output rx_valid,
        output frame_err,
        output busy_rx
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled serial input, mid-bit sampling, one-cycle
// valid / framing-error strobes and a break-hold state after a bad stop bit.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 10416,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input logic      fpga_clk,
    input logic      rst,
    uart_rx_if.slave rx
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      sync_q;
    logic            sin_s;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      dout_q, dout_d;
    logic            rx_valid_q, rx_valid_d;
    logic            frame_err_q, frame_err_d;

    assign sin_s = sync_q[1];

    always_ff @(posedge fpga_clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            sync_q      <= 2'b11;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shreg_q     <= 8'h00;
            dout_q      <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[0], rx.sin};
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            dout_q      <= dout_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        dout_d      = dout_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!sin_s) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d = '0;
                    // A high mid-start sample means the falling edge was a glitch.
                    if (!sin_s) begin
                        state_d = StData;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = sin_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (sin_s) begin
                        dout_d     = shreg_q;
                        rx_valid_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end
                end
            end
            StBreak: begin
                // Hold off restart detection until the line is released.
                cnt_d = '0;
                if (sin_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    assign rx.dout      = dout_q;
    assign rx.rx_valid  = rx_valid_q;
    assign rx.frame_err = frame_err_q;
    assign rx.busy_rx   = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: line-history reference decoder checked every
// cycle, plus directed frames with hand-computed timing and data expectations.
module tb_uart_rx;

    localparam int N = 16;
    localparam int H = 8;
    localparam int HistLen = 8192;

    logic fpga_clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_if bus ();

    uart_rx #(
        .CLKS_PER_BIT(N),
        .HALF_BIT    (H)
    ) dut (
        .fpga_clk(fpga_clk),
        .rst     (rst),
        .rx      (bus)
    );

    always #5 fpga_clk = ~fpga_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Line value as seen by the receiver at each rising edge (reset forces idle).
    logic hist [0:HistLen-1];
    int   edge_n = 0;

    always @(posedge fpga_clk) begin
        if (edge_n >= HistLen) begin
            $display("FAIL cycle_budget: edges %0d exceeded %0d", edge_n, HistLen);
            $fatal(1, "cycle budget exhausted");
        end
        hist[edge_n] = rst ? 1'b1 : bus.sin;
        edge_n = edge_n + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference decoder state: start edge of the current frame, break hold, earliest idle look.
    int         m_start = -1;
    logic       m_brk   = 1'b0;
    int         m_next  = 0;
    logic [7:0] m_dout  = 8'h00;
    logic       m_v, m_e, ss;
    logic [7:0] m_byte;
    int         c;

    int         n_valid = 0;
    int         n_err   = 0;
    int         last_valid_edge = 0;
    int         last_err_edge   = 0;
    logic [7:0] got_q [$];
    int         got_edge_q [$];

    always begin
        @(negedge fpga_clk);
        #1;
        c   = edge_n - 1;
        m_v = 1'b0;
        m_e = 1'b0;
        if (rst || c < 2) begin
            m_start = -1;
            m_brk   = 1'b0;
            m_next  = c + 1;
            m_dout  = 8'h00;
        end else begin
            ss = hist[c-2];
            if (m_brk) begin
                if (ss) begin
                    m_brk  = 1'b0;
                    m_next = c + 1;
                end
            end else if (m_start < 0) begin
                if (c >= m_next && !ss) m_start = c;
            end else if (c == m_start + H) begin
                if (ss) begin
                    m_start = -1;
                    m_next  = c + 1;
                end
            end else if (c == m_start + H + 9 * N) begin
                for (int i = 0; i < 8; i++) m_byte[i] = hist[m_start + H + (i + 1) * N - 2];
                if (ss) begin
                    m_v    = 1'b1;
                    m_dout = m_byte;
                    m_next = c + 1;
                end else begin
                    m_e   = 1'b1;
                    m_brk = 1'b1;
                end
                m_start = -1;
            end
        end
        if (c >= 0) begin
            check("rx_valid", {31'd0, bus.rx_valid}, {31'd0, m_v});
            check("frame_err", {31'd0, bus.frame_err}, {31'd0, m_e});
            check("busy_rx", {31'd0, bus.busy_rx}, {31'd0, (m_start >= 0) || m_brk});
            check("dout", {24'd0, bus.dout}, {24'd0, m_dout});
        end
        if (bus.rx_valid === 1'b1) begin
            n_valid = n_valid + 1;
            last_valid_edge = c;
            got_q.push_back(bus.dout);
            got_edge_q.push_back(c);
        end
        if (bus.frame_err === 1'b1) begin
            n_err = n_err + 1;
            last_err_edge = c;
        end
    end

    int f_edge0 = 0;

    task automatic send_byte(input logic [7:0] b, input logic stop, input int max_cycles);
        logic [9:0] fr;
        int         k;
        fr = {stop, b, 1'b0};
        k  = 0;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < N; j++) begin
                if (k < max_cycles) begin
                    @(negedge fpga_clk);
                    bus.sin = fr[i];
                    if (k == 0) f_edge0 = edge_n;
                    k = k + 1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge fpga_clk);
            bus.sin = 1'b1;
        end
    endtask

    int         v0, e0, q0, e_a;
    logic [7:0] sent [5];

    initial begin
        bus.sin = 1'b1;
        rst     = 1'b1;
        repeat (3) @(negedge fpga_clk);
        rst = 1'b0;
        #1;
        check("reset_dout", {24'd0, bus.dout}, 32'h00);
        check("reset_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("reset_frame_err", {31'd0, bus.frame_err}, 32'd0);
        check("reset_busy", {31'd0, bus.busy_rx}, 32'd0);
        for (int i = 0; i < 100; i++) begin
            idle(1);
            #1;
            check("idle_busy", {31'd0, bus.busy_rx}, 32'd0);
        end

        // Good frame 0xA5: strobe lands 154 edges after the first low sample.
        v0 = n_valid;
        e0 = n_err;
        send_byte(8'hA5, 1'b1, 10 * N);
        idle(5);
        #1;
        check("a5_count", n_valid, v0 + 1);
        check("a5_latency", last_valid_edge - f_edge0, 154);
        check("a5_dout", {24'd0, bus.dout}, 32'hA5);
        check("a5_no_err", n_err, e0);

        // 3-cycle glitch is rejected.
        v0 = n_valid;
        repeat (3) begin
            @(negedge fpga_clk);
            bus.sin = 1'b0;
        end
        idle(12);
        #1;
        check("glitch_busy", {31'd0, bus.busy_rx}, 32'd0);
        idle(10);
        check("glitch_no_valid", n_valid, v0);
        check("glitch_no_err", n_err, e0);

        // Bad stop bit followed by a held-low break.
        v0 = n_valid;
        send_byte(8'h3C, 1'b0, 10 * N);
        repeat (40) begin
            @(negedge fpga_clk);
            bus.sin = 1'b0;
        end
        #1;
        check("ferr_count", n_err, e0 + 1);
        check("ferr_latency", last_err_edge - f_edge0, 154);
        check("ferr_dout_kept", {24'd0, bus.dout}, 32'hA5);
        check("ferr_busy_low", {31'd0, bus.busy_rx}, 32'd1);
        @(negedge fpga_clk);
        bus.sin = 1'b1;
        @(negedge fpga_clk);
        @(negedge fpga_clk);
        #1;
        check("break_busy_held", {31'd0, bus.busy_rx}, 32'd1);
        @(negedge fpga_clk);
        #1;
        check("break_busy_clear", {31'd0, bus.busy_rx}, 32'd0);
        idle(5);
        send_byte(8'h81, 1'b1, 10 * N);
        idle(5);
        #1;
        check("after_break_dout", {24'd0, bus.dout}, 32'h81);
        check("after_break_count", n_valid, v0 + 1);
        check("after_break_err", n_err, e0 + 1);

        // Back-to-back frames with no idle gap.
        q0 = got_q.size();
        send_byte(8'h00, 1'b1, 10 * N);
        send_byte(8'hFF, 1'b1, 10 * N);
        idle(5);
        check("b2b_count", got_q.size(), q0 + 2);
        if (got_q.size() >= q0 + 2) begin
            check("b2b_first", {24'd0, got_q[q0]}, 32'h00);
            check("b2b_second", {24'd0, got_q[q0+1]}, 32'hFF);
            check("b2b_spacing", got_edge_q[q0+1] - got_edge_q[q0], 160);
        end

        // Reset during data bit 4 of 0x55 discards the frame.
        v0 = n_valid;
        send_byte(8'h55, 1'b1, 5 * N + 8);
        @(negedge fpga_clk);
        rst     = 1'b1;
        bus.sin = 1'b1;
        repeat (3) @(negedge fpga_clk);
        rst = 1'b0;
        #1;
        check("abort_busy", {31'd0, bus.busy_rx}, 32'd0);
        check("abort_dout_reset", {24'd0, bus.dout}, 32'h00);
        idle(20);
        check("abort_no_valid", n_valid, v0);
        send_byte(8'h12, 1'b1, 10 * N);
        idle(5);
        #1;
        check("abort_next_dout", {24'd0, bus.dout}, 32'h12);
        check("abort_next_count", n_valid, v0 + 1);

        // Loopback of random bytes with random idle gaps.
        e_a = n_err;
        q0  = got_q.size();
        for (int i = 0; i < 5; i++) begin
            sent[i] = 8'($urandom);
            send_byte(sent[i], 1'b1, 10 * N);
            idle(int'($urandom_range(0, 3)));
        end
        idle(5);
        check("loop_count", got_q.size(), q0 + 5);
        for (int i = 0; i < 5; i++) begin
            if (got_q.size() > q0 + i) begin
                check("loop_byte", {24'd0, got_q[q0+i]}, {24'd0, sent[i]});
            end
        end
        check("loop_no_err", n_err, e_a);

        @(negedge fpga_clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for 8N1 serial frames. It is the stage directly downstream of `uart_tx`, consuming its `sout` line. Ports: `sin` serial in; `dout` parallel byte out, with a one-cycle `rx_valid` strobe and `frame_err` flag. The block oversamples `sin` on `fpga_clk`, needs no external baud clock, and samples each bit at mid-bit.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 10416: `fpga_clk` cycles per bit (N); legal range ≥ 4.
- `HALF_BIT`, default `CLKS_PER_BIT/2` (floor): cycles from start detection to the start-bit sample (H).

Ports:
- `fpga_clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `sin`  in  1  serial input, idle high, asynchronous to `fpga_clk`.
- `dout`  out  8  last good received byte; changes only when `rx_valid` pulses.
- `rx_valid`  out  1  one-cycle pulse when a frame completes with a good stop bit.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples low.
- `busy_rx`  out  1  high whenever the state is not IDLE.

## Operation
- `sin` passes through a 2-FF synchronizer (reset value 1) to give `sin_s`. All logic uses `sin_s` only.
- A bit counter `cnt` (width `$clog2(CLKS_PER_BIT)`) clears on every state entry. A bit index `idx` (3 bits) tracks the data bit.
- Frame: start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- State machine:
  - IDLE: when `sin_s`==0, go to START.
  - START: when `cnt`==H-1, sample `sin_s` on the next edge.
    - Sample is 0: go to DATA with `idx`=0.
    - Sample is 1: treat as a glitch and return to IDLE with no outputs.
  - DATA: when `cnt`==N-1, shift `sin_s` into `shreg[idx]` and increment `idx`. After bit 7, go to STOP.
  - STOP: when `cnt`==N-1, sample `sin_s`.
    - Sample is 1: load `dout`<=`shreg`, pulse `rx_valid`, go to IDLE.
    - Sample is 0: pulse `frame_err`, leave `dout` unchanged, go to BREAK.
  - BREAK: wait until `sin_s`==1, then go to IDLE. This prevents false restarts inside a held-low break condition.
- No handshake. The consumer must capture `dout` on the `rx_valid` cycle. `dout` holds until the next good frame.
- Reset values: state=IDLE, `dout`=8'h00, `rx_valid`=0, `frame_err`=0, `busy_rx`=0, synchronizer FFs=1, `cnt`=0, `idx`=0.
- Reset mid-frame aborts immediately. No pulse is emitted and the partial byte is discarded.
- `rx_valid` and `frame_err` are never high in the same cycle.

## Timing
- Edge numbering: edge 0 is the first `fpga_clk` rising edge that samples `sin` low.
  - `sin_s` is low after edge 1.
  - START is entered at edge 2.
  - The start bit is sampled at edge 2+H.
  - Data bit i is sampled at edge 2+H+(i+1)·N.
  - The stop bit is sampled at edge 2+H+9N.
- `rx_valid`/`frame_err` are high for exactly the cycle following edge 2+H+9N.
- `busy_rx` rises after edge 2 and falls together with the `rx_valid` assertion. After a framing error, it falls only after the line returns high.
- Back-to-back frames: a start bit immediately following the stop bit is detected. IDLE sees `sin_s`==0 in the first cycle after returning. The drift budget is ±H cycles over 10 bits.
- Minimum glitch rejected: any low pulse shorter than H cycles on `sin_s`.

## Test plan
- Reset, with `sin`=1 held: all outputs at their reset values; `busy_rx`=0 for 100 cycles.
- N=16, H=8, drive frame 0xA5: `rx_valid` high for one cycle after edge 154, `dout`=8'hA5, `frame_err`=0.
- N=16, drive `sin` low for 3 cycles then high: no `rx_valid`, no `frame_err`; `busy_rx` returns to 0 within 12 cycles.
- N=16, send 0x3C with stop bit 0, then hold low 40 cycles, then high: `frame_err` pulses once after edge 154 and `dout` keeps its prior value. `busy_rx` stays high until 2 cycles after `sin` rises. A following 0x81 frame then receives correctly.
- N=16, back-to-back 0x00 then 0xFF with no idle gap: two `rx_valid` pulses 160 cycles apart, `dout`=8'h00 then 8'hFF.
- N=16, assert `rst` during data bit 4 of frame 0x55, then release and send 0x12: no pulse for the aborted frame; next `rx_valid` gives `dout`=8'h12.
- Loopback: `uart_tx` `sout` drives `sin` with matched bit period, 5 random bytes: every byte is reproduced on `dout` in order with zero framing errors.
